// File: rtl/lr_regfile.sv
// LR35902 register file + flags: comb reads of A/B/F ports, write-back/pointer updates at clk; strobes only, no backpressure.
// Optional `LR_REGFILE_BYPASS_EN` forwards the same-cycle write value to the read ports and flag output.
module lr_regfile #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] SP_RESET = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ra_sel,
  input  logic [3:0]  rb_sel,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [3:0]  f,
  input  logic        we,
  input  logic [3:0]  wsel,
  input  logic [15:0] wd,
  input  logic [3:0]  fwe,
  input  logic [3:0]  nf,
  input  logic        pc_inc,
  input  logic        sp_inc,
  input  logic        sp_dec,
  input  logic        hl_inc,
  input  logic        hl_dec
);

  logic [7:0]  reg_a, reg_b, reg_c, reg_d, reg_e, reg_h, reg_l;
  logic [3:0]  flags;
  logic [15:0] sp, pc;

  logic [7:0]  a_nx, b_nx, c_nx, d_nx, e_nx, h_nx, l_nx;
  logic [3:0]  flags_nx;
  logic [15:0] sp_nx, pc_nx;
  logic [15:0] hl_step, sp_step;
  logic [15:0] rdv [16];

  // Pointer steps first; a same-cycle write then overrides only the bytes it targets.
  always_comb begin
    hl_step = {reg_h, reg_l};
    if (hl_inc && !hl_dec)
      hl_step = hl_step + 16'd1;
    else if (hl_dec && !hl_inc)
      hl_step = hl_step - 16'd1;

    sp_step = sp;
    if (sp_inc && !sp_dec)
      sp_step = sp + 16'd1;
    else if (sp_dec && !sp_inc)
      sp_step = sp - 16'd1;

    a_nx = reg_a;
    b_nx = reg_b;
    c_nx = reg_c;
    d_nx = reg_d;
    e_nx = reg_e;
    h_nx = hl_step[15:8];
    l_nx = hl_step[7:0];
    sp_nx = sp_step;
    pc_nx = pc_inc ? pc + 16'd1 : pc;
    // Per-bit select keeps an X on a masked-off nf bit out of the held flag.
    for (int i = 0; i < 4; i++)
      flags_nx[i] = fwe[i] ? nf[i] : flags[i];

    if (we) begin
      case (wsel)
        4'd0:  b_nx = wd[7:0];
        4'd1:  c_nx = wd[7:0];
        4'd2:  d_nx = wd[7:0];
        4'd3:  e_nx = wd[7:0];
        4'd4:  h_nx = wd[7:0];
        4'd5:  l_nx = wd[7:0];
        4'd6:  a_nx = wd[7:0];
        4'd7:  flags_nx = wd[7:4];
        4'd8:  {b_nx, c_nx} = wd;
        4'd9:  {d_nx, e_nx} = wd;
        4'd10: {h_nx, l_nx} = wd;
        4'd11: begin
          a_nx     = wd[15:8];
          flags_nx = wd[7:4];
        end
        4'd12: sp_nx = wd;
        4'd13: pc_nx = wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a <= 8'h00;
      reg_b <= 8'h00;
      reg_c <= 8'h00;
      reg_d <= 8'h00;
      reg_e <= 8'h00;
      reg_h <= 8'h00;
      reg_l <= 8'h00;
      flags <= 4'h0;
      sp    <= SP_RESET;
      pc    <= PC_RESET;
    end else begin
      reg_a <= a_nx;
      reg_b <= b_nx;
      reg_c <= c_nx;
      reg_d <= d_nx;
      reg_e <= e_nx;
      reg_h <= h_nx;
      reg_l <= l_nx;
      flags <= flags_nx;
      sp    <= sp_nx;
      pc    <= pc_nx;
    end
  end

  always_comb begin
    rdv[0]  = {8'h00, reg_b};
    rdv[1]  = {8'h00, reg_c};
    rdv[2]  = {8'h00, reg_d};
    rdv[3]  = {8'h00, reg_e};
    rdv[4]  = {8'h00, reg_h};
    rdv[5]  = {8'h00, reg_l};
    rdv[6]  = {8'h00, reg_a};
    rdv[7]  = {8'h00, flags, 4'h0};
    rdv[8]  = {reg_b, reg_c};
    rdv[9]  = {reg_d, reg_e};
    rdv[10] = {reg_h, reg_l};
    rdv[11] = {reg_a, flags, 4'h0};
    rdv[12] = sp;
    rdv[13] = pc;
    rdv[14] = 16'h0000;
    rdv[15] = 16'h0000;
  end

`ifdef LR_REGFILE_BYPASS_EN
  logic [15:0] wrv [16];
  logic        fwd_a, fwd_b;

  // Value the selected register would read after this write; reserved selects never match.
  always_comb begin
    for (int i = 0; i < 7; i++)
      wrv[i] = {8'h00, wd[7:0]};
    wrv[7]  = {8'h00, wd[7:4], 4'h0};
    wrv[8]  = wd;
    wrv[9]  = wd;
    wrv[10] = wd;
    wrv[11] = {wd[15:8], wd[7:4], 4'h0};
    wrv[12] = wd;
    wrv[13] = wd;
    wrv[14] = 16'h0000;
    wrv[15] = 16'h0000;
  end

  assign fwd_a = we && (ra_sel == wsel) && (ra_sel[3:1] != 3'b111);
  assign fwd_b = we && (rb_sel == wsel) && (rb_sel[3:1] != 3'b111);
  assign a = fwd_a ? wrv[ra_sel] : rdv[ra_sel];
  assign b = fwd_b ? wrv[rb_sel] : rdv[rb_sel];
  assign f = flags_nx;
`else
  assign a = rdv[ra_sel];
  assign b = rdv[rb_sel];
  assign f = flags;
`endif

endmodule

// File: doc/lr_regfile.md
# lr_regfile

Register file and flag register of the LR35902 core, sitting directly upstream of the ALU. It supplies ALU operands `a`/`b` and current flags `f`, and captures ALU result `d` and flag result `nf` as write-back at the clock edge. It also owns the autonomous pointer updates: PC increment, SP inc/dec and HL inc/dec for LDI/LDD/PUSH/POP.

## Interface
- `PC_RESET`, 16'h0000, PC value after reset
- `SP_RESET`, 16'hFFFE, SP value after reset
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `ra_sel` in 4: read select, port A
- `rb_sel` in 4: read select, port B
- `a` out 16: port A data, drives ALU `a`
- `b` out 16: port B data, drives ALU `b`
- `f` out 4: {Z,N,H,C} = F[7:4], drives ALU `f`
- `we` in 1: register write enable
- `wsel` in 4: write select
- `wd` in 16: write data, normally ALU `d`
- `fwe` in 4: per-flag write mask {Z,N,H,C}
- `nf` in 4: new flags, normally ALU `nf`
- `pc_inc` in 1: PC <= PC+1
- `sp_inc`, `sp_dec` in 1: SP <= SP±1
- `hl_inc`, `hl_dec` in 1: HL <= HL±1

## Operation
- Select encoding:
  - 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 A, 7 F
  - 8 BC, 9 DE, 10 HL, 11 AF, 12 SP, 13 PC
  - 14–15 reserved: read 16'h0000, writes ignored
- 8-bit reads return {8'h00, reg}. 16-bit pair reads return {high, low}.
- 8-bit writes take `wd[7:0]`. Pair writes take high = `wd[15:8]`, low = `wd[7:0]`.
- F[3:0] is hardwired 0. Any write to F or AF discards bits 3:0.
- Flag write: for each bit i with `fwe[i]`=1, the corresponding flag takes `nf[i]`; masked bits hold.
  - X on a masked-off `nf` bit (ALU drives `nf[2]`=x) must not propagate.
- Pointer arithmetic is modulo 2^16:
  - HL 16'hFFFF + 1 = 16'h0000
  - SP 16'h0000 − 1 = 16'hFFFF
  - PC 16'hFFFF + 1 = 16'h0000
- Same-cycle conflicts, resolved per register:
  - `we` targeting F/AF beats `fwe`: the whole F comes from `wd`.
  - `we` targeting H, L or HL beats `hl_inc`/`hl_dec` on the written byte(s). Any unwritten byte of HL takes its byte of HL±1.
  - `we` to SP beats `sp_inc`/`sp_dec`; `we` to PC beats `pc_inc`.
  - `hl_inc` with `hl_dec` leaves HL unchanged; `sp_inc` with `sp_dec` leaves SP unchanged.
  - Independent registers update in parallel; e.g. `we` BC, `fwe`, `pc_inc`, `sp_dec` and `hl_inc` all in one cycle is legal.
- Reset:
  - A,F,B,C,D,E,H,L = 8'h00, SP = `SP_RESET`, PC = `PC_RESET`.
  - `rst` overrides every write and increment in the same cycle.
  - After the reset edge, `a`/`b` reflect reset values for whatever is selected, and `f` = 4'h0.

## Timing
- Reads are combinational from registered state: zero-cycle latency from `ra_sel`/`rb_sel` to `a`/`b`.
- Writes, flag updates and pointer updates commit at the rising edge and are visible from the next cycle.
- Without bypass, a read in the same cycle as a write returns the old value.
- No handshake: every enable is a single-cycle strobe, acted on each cycle it is high.
- The ALU path is combinational, so a read → ALU → write-back loop completes in one cycle.

## Configuration
- `LR_REGFILE_BYPASS_EN` defined: write-to-read forwarding.
  - When `we`=1 and `ra_sel`==`wsel` (or `rb_sel`==`wsel`), and the select is not reserved, that port returns the write value in the same cycle: 8-bit selects give {8'h00, `wd[7:0]`}; F/AF have low nibble zeroed.
  - `f` returns the post-mask flag value under `fwe`, or under a `we` to F/AF.
  - Partial overlaps (write H, read HL) and pointer increments are not forwarded.
- Undefined: no forwarding; `a`, `b` and `f` are purely registered-state reads.

## Test plan
- Assert `rst` for one cycle, then read with `ra_sel`=13, `rb_sel`=12 → `a`=16'h0000, `b`=16'hFFFE; with sel 11 → 16'h0000; `f`=4'h0.
- `we`=1, `wsel`=8, `wd`=16'h1234; next cycle `ra_sel`=0, `rb_sel`=1 → `a`=16'h0012, `b`=16'h0034.
- `fwe`=4'b1011, `nf`=4'b1x11 with N previously 0 → next cycle `f`=4'b1011, and read of F = 16'h00B0. Then `we` AF=16'h12FF → AF reads 16'h12F0.
- HL=16'hFFFF, pulse `hl_inc` → HL=16'h0000. Then HL=16'h12FF with `hl_inc` and `we` L=8'h55 in the same cycle → HL=16'h1355. SP=16'h0000 with `sp_dec` → 16'hFFFF.
- PC=16'h0100 with `pc_inc`=1 for 3 cycles → 16'h0103. Then `we` PC=16'h4000 with `pc_inc` in the same cycle → 16'h4000.
- BC=16'h0000, then `we` BC=16'hABCD with `ra_sel`=8 in the same cycle → `a`=16'hABCD with `LR_REGFILE_BYPASS_EN`, 16'h0000 without; next cycle 16'hABCD in both builds.
